fetch_issue_unit: RTL and testbench
===================================

// Module: fetch_issue_unit
// PURPOSE
//  Fetch-request issuer directly downstream of the fetch-PC request buffer.
//  - Sends the held PC to the ICache over a valid/ready request channel.
//  - Pulses the buffer's write enable when a request is accepted, so the buffer advances.
//  - Tags in-order ICache responses with their PCs and queues {pc, inst} pairs to decode.
//  - On a pipeline flush, discards queued work and any responses still in flight.
// PARAMETERS
//  WORD      32  datapath/address width
//  FIFO_DEPTH 4  instruction queue entries (power of 2, >=2)
//  MAX_OUT    2  max outstanding ICache requests (power of 2, <=FIFO_DEPTH)
// PORTS
//  clk           in   1     single clock, all state on posedge
//  rst           in   1     synchronous, active-high reset
//  pc_i          in   WORD  current fetch PC from request buffer
//  pc_we_o       out  1     advance request buffer (= request accepted this cycle)
//  flush_i       in   1     pipeline redirect/flush
//  ic_req_valid_o out 1     ICache request valid
//  ic_req_addr_o out  WORD  ICache request address (= pc_i)
//  ic_req_ready_i in  1     ICache accepts request
//  ic_resp_valid_i in 1     ICache response valid (in order, max 1 per cycle)
//  ic_resp_data_i in  WORD  fetched instruction
//  ifq_valid_o   out  1     queue head valid to decode
//  ifq_pc_o      out  WORD  PC of queue head
//  ifq_inst_o    out  WORD  instruction of queue head
//  ifq_ready_i   in   1     decode pops head when valid&ready
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=RUN; queue, PC-tag queue, outstanding count and discard count all cleared.
//   - All outputs read 0 in the cycle after the reset posedge.
//  State RUN, issue condition:
//   - ic_req_valid_o = !flush_i & out_cnt<MAX_OUT & (out_cnt+q_cnt)<FIFO_DEPTH.
//   - The credit check guarantees queue space for every response; no response is ever refused.
//  Request acceptance:
//   - Accepted when ic_req_valid_o & ic_req_ready_i.
//   - Same cycle: pc_we_o=1 (combinational); pc_i is pushed into the tag queue; out_cnt+1.
//   - pc_i is stable except after pc_we_o or flush.
//   - Valid may drop without acceptance only on flush_i or a credit change.
//  Response:
//   - ic_resp_valid_i pops the tag-queue head and decrements out_cnt.
//   - In RUN: pushes {tag, data} into the queue, visible on ifq_* the next cycle.
//   - Accept and response in the same cycle: out_cnt is unchanged net.
//  Output queue:
//   - First-word fall-through; ifq_valid_o = q_cnt!=0.
//   - Push and pop in the same cycle leave q_cnt unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Flush (flush_i=1, either state):
//   - No request issued that cycle; queue emptied (a pop that cycle is ignored).
//   - Response arriving that cycle is dropped.
//   - disc_cnt <= out_cnt - resp; tag queue keeps those entries for draining.
//   - Next state = DRAIN if disc_cnt' != 0, else RUN.
//  State DRAIN:
//   - No issue.
//   - Each response is dropped, pops its tag, decrements out_cnt and disc_cnt.
//   - The response that brings disc_cnt to 0 moves the state to RUN; issue resumes the following cycle.
//  Counter widths:
//   - out_cnt/disc_cnt are clog2(MAX_OUT)+1 bits; q_cnt is clog2(FIFO_DEPTH)+1 bits.
//   - No overflow or underflow is possible under the rules above.
//  Reset mid-operation: state is discarded immediately; late ICache responses are the ICache's reset responsibility.
// TESTING
//  1 Reset then pc_i=0x1C000000, ready=1 -> pc_we_o=1 on cycle 1; resp 0x02800000 -> ifq {0x1C000000,0x02800000} next cycle.
//  2 ready=1, no responses -> exactly MAX_OUT=2 accepts, then req_valid=0 until a response arrives.
//  3 ifq_ready=0, responses flowing -> issue stops at q_cnt+out_cnt=4; queue holds 4 entries in PC order, none lost.
//  4 2 outstanding, flush_i with resp same cycle -> DRAIN, disc_cnt=1; next resp dropped, then RUN; new pc_i=0x1C000100 issued next cycle.
//  5 flush_i with 0 outstanding and queue full -> queue empty next cycle, state stays RUN, issue same+1 cycle.
//  6 Random ready/resp/ifq_ready/flush 10k cycles vs scoreboard -> ifq order = accepted PC order, no pre-flush PC after flush.

Source files
------------

// File: rtl/fetch_issue_unit_if.sv
// Handshake bundle between the fetch issue unit and its neighbours.
// Groups the request-buffer handshake (pc/pc_we), the flush strobe, the
// ICache request and response channels, and the instruction-queue head
// presented to decode.
//   pc            current fetch PC held by the request buffer
//   pc_we         request buffer advance strobe (a request was accepted)
//   flush         pipeline redirect/flush
//   ic_req_*      ICache request channel (valid/ready, address)
//   ic_resp_*     in-order ICache response channel (valid, data)
//   ifq_*         instruction-queue head to decode (valid/ready, pc, inst)
// master: the fetch issue unit; slave: the surrounding environment.
interface fetch_issue_unit_if #(
    parameter int WORD = 32
);
    logic [WORD-1:0] pc;
    logic            pc_we;
    logic            flush;
    logic            ic_req_valid;
    logic [WORD-1:0] ic_req_addr;
    logic            ic_req_ready;
    logic            ic_resp_valid;
    logic [WORD-1:0] ic_resp_data;
    logic            ifq_valid;
    logic [WORD-1:0] ifq_pc;
    logic [WORD-1:0] ifq_inst;
    logic            ifq_ready;

    modport master (
        input  pc, flush, ic_req_ready, ic_resp_valid, ic_resp_data, ifq_ready,
        output pc_we, ic_req_valid, ic_req_addr, ifq_valid, ifq_pc, ifq_inst
    );

    modport slave (
        output pc, flush, ic_req_ready, ic_resp_valid, ic_resp_data, ifq_ready,
        input  pc_we, ic_req_valid, ic_req_addr, ifq_valid, ifq_pc, ifq_inst
    );
endinterface

// File: rtl/fetch_issue_unit.sv
// Fetch-request issuer sitting right after the fetch-PC request buffer.
// Sends the held PC to the ICache, advances the buffer on acceptance, tags
// the in-order ICache responses with their PCs and queues {pc, inst} pairs
// for decode. A flush empties the queue and discards responses that are
// still in flight for requests issued before it.
// Ports:
//   clk   single clock, all state on the rising edge
//   rst   synchronous active-high reset
//   bus   fetch_issue_unit_if.master (buffer, flush, ICache, decode queue)
module fetch_issue_unit #(
    parameter int WORD       = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_issue_unit_if.master   bus
);

    localparam int OW = $clog2(MAX_OUT) + 1;
    localparam int QW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
    localparam logic [QW:0]   DEPTH_C   = (QW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_r;
    logic            init_r;
    logic [OW-1:0]   out_cnt_r;
    logic [OW-1:0]   disc_cnt_r;
    logic [QW-1:0]   q_cnt_r;
    logic [PW-1:0]   q_wr_ptr_r;
    logic [PW-1:0]   q_rd_ptr_r;
    logic [TW-1:0]   tag_wr_ptr_r;
    logic [TW-1:0]   tag_rd_ptr_r;
    logic [WORD-1:0] tag_mem_r  [MAX_OUT];
    logic [WORD-1:0] q_pc_r     [FIFO_DEPTH];
    logic [WORD-1:0] q_inst_r   [FIFO_DEPTH];

    logic [QW:0]     credit_s;
    logic [OW-1:0]   out_left_s;
    logic            issue_s;
    logic            accept_s;
    logic            resp_s;
    logic            push_s;
    logic            pop_s;

    function automatic logic [PW-1:0] q_ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [TW-1:0] tag_ptr_next(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUT - 1)) ? '0 : p + TW'(1);
    endfunction

    // Outstanding plus queued entries: reserves a queue slot for every request in flight.
    assign credit_s   = (QW + 1)'(out_cnt_r) + (QW + 1)'(q_cnt_r);
    // Outstanding requests left once this cycle's response (if any) retires.
    assign out_left_s = out_cnt_r - OW'(resp_s);

    // Issue, acceptance and queue push/pop decisions for this cycle.
    always_comb begin
        issue_s  = 1'b0;
        accept_s = 1'b0;
        resp_s   = bus.ic_resp_valid;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        // init_r holds issue off for the first cycle after reset so every output reads 0 then.
        if (!init_r && (state_r == RUN) && !bus.flush &&
            (out_cnt_r < MAX_OUT_C) && (credit_s < DEPTH_C)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        accept_s = issue_s & bus.ic_req_ready;
        if (!bus.flush) begin
            push_s = resp_s & (state_r == RUN);
            pop_s  = (q_cnt_r != '0) & bus.ifq_ready;
        end else begin
            push_s = 1'b0;
            pop_s  = 1'b0;
        end
    end

    assign bus.ic_req_valid = issue_s;
    assign bus.pc_we        = accept_s;
    assign bus.ic_req_addr  = bus.pc;
    assign bus.ifq_valid    = (q_cnt_r != '0);
    assign bus.ifq_pc       = q_pc_r[q_rd_ptr_r];
    assign bus.ifq_inst     = q_inst_r[q_rd_ptr_r];

    // Control state: FSM, counters and queue pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= RUN;
            init_r       <= 1'b1;
            out_cnt_r    <= '0;
            disc_cnt_r   <= '0;
            q_cnt_r      <= '0;
            q_wr_ptr_r   <= '0;
            q_rd_ptr_r   <= '0;
            tag_wr_ptr_r <= '0;
            tag_rd_ptr_r <= '0;
        end else begin
            init_r <= 1'b0;

            // Tag queue tracks every outstanding request, whatever the state.
            case ({accept_s, resp_s})
                2'b10:   out_cnt_r <= out_cnt_r + OW'(1);
                2'b01:   out_cnt_r <= out_cnt_r - OW'(1);
                default: out_cnt_r <= out_cnt_r;
            endcase
            if (accept_s) begin
                tag_wr_ptr_r <= tag_ptr_next(tag_wr_ptr_r);
            end
            if (resp_s) begin
                tag_rd_ptr_r <= tag_ptr_next(tag_rd_ptr_r);
            end

            if (bus.flush) begin
                // Everything still in flight after this cycle belongs to the old stream.
                q_cnt_r    <= '0;
                q_wr_ptr_r <= '0;
                q_rd_ptr_r <= '0;
                disc_cnt_r <= out_left_s;
                state_r    <= (out_left_s != '0) ? DRAIN : RUN;
            end else begin
                if (push_s) begin
                    q_wr_ptr_r <= q_ptr_next(q_wr_ptr_r);
                end
                if (pop_s) begin
                    q_rd_ptr_r <= q_ptr_next(q_rd_ptr_r);
                end
                case ({push_s, pop_s})
                    2'b10:   q_cnt_r <= q_cnt_r + QW'(1);
                    2'b01:   q_cnt_r <= q_cnt_r - QW'(1);
                    default: q_cnt_r <= q_cnt_r;
                endcase
                case (state_r)
                    RUN: begin
                        state_r <= RUN;
                    end
                    DRAIN: begin
                        if (resp_s) begin
                            disc_cnt_r <= disc_cnt_r - OW'(1);
                            state_r    <= (disc_cnt_r == OW'(1)) ? RUN : DRAIN;
                        end
                    end
                    default: begin
                        state_r <= RUN;
                    end
                endcase
            end
        end
    end

    // Storage: PC tags of outstanding requests and the {pc, inst} queue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                tag_mem_r[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                q_pc_r[i]   <= '0;
                q_inst_r[i] <= '0;
            end
        end else begin
            if (accept_s) begin
                tag_mem_r[tag_wr_ptr_r] <= bus.pc;
            end
            if (push_s) begin
                q_pc_r[q_wr_ptr_r]   <= tag_mem_r[tag_rd_ptr_r];
                q_inst_r[q_wr_ptr_r] <= bus.ic_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Bench for fetch_issue_unit: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations and a random run.
module tb_fetch_issue_unit;

    localparam int WORD  = 32;
    localparam int DEPTH = 4;
    localparam int MOUT  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst;

    fetch_issue_unit_if #(.WORD(WORD)) bus ();

    fetch_issue_unit #(
        .WORD(WORD), .FIFO_DEPTH(DEPTH), .MAX_OUT(MOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_tagq[$];
    ent_t        m_ifq[$];
    int          m_disc  = 0;
    bit          m_fresh = 1'b0;
    bit          m_live  = 1'b0;

    // Values sampled at the negedge of the last cyc() call
    logic        s_valid, s_we, s_qv;
    logic [31:0] s_addr, s_qpc, s_qinst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_valid();
        return m_live && !m_fresh && (m_disc == 0) && !bus.flush &&
               (m_tagq.size() < MOUT) && ((m_tagq.size() + m_ifq.size()) < DEPTH);
    endfunction

    task automatic m_reset();
        m_tagq.delete();
        m_ifq.delete();
        m_disc  = 0;
        m_fresh = 1'b1;
        m_live  = 1'b1;
    endtask

    // Advance the model by one clock using the inputs held during that cycle.
    task automatic m_step();
        bit          acc;
        bit          pop;
        logic [31:0] tag;
        acc = m_valid() && bus.ic_req_ready;
        pop = !bus.flush && (m_ifq.size() != 0) && bus.ifq_ready;
        if (pop) void'(m_ifq.pop_front());
        if (bus.ic_resp_valid && (m_tagq.size() != 0)) begin
            tag = m_tagq.pop_front();
            if (!bus.flush && (m_disc == 0)) m_ifq.push_back('{pc: tag, inst: bus.ic_resp_data});
            else if (!bus.flush) m_disc--;
        end
        if (bus.flush) begin
            m_ifq.delete();
            m_disc = m_tagq.size();
        end
        if (acc) m_tagq.push_back(bus.pc);
        m_fresh = 1'b0;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        bit ev;
        if (m_live && !rst) begin
            ev = m_valid();
            chk("req_valid", 32'(bus.ic_req_valid), 32'(ev));
            chk("pc_we", 32'(bus.pc_we), 32'(ev && bus.ic_req_ready));
            chk("req_addr", bus.ic_req_addr, bus.pc);
            chk("ifq_valid", 32'(bus.ifq_valid), 32'(m_ifq.size() != 0));
            if (m_ifq.size() != 0) begin
                chk("ifq_pc", bus.ifq_pc, m_ifq[0].pc);
                chk("ifq_inst", bus.ifq_inst, m_ifq[0].inst);
            end else if (m_fresh) begin
                chk("reset_ifq_pc", bus.ifq_pc, 32'h0);
                chk("reset_ifq_inst", bus.ifq_inst, 32'h0);
            end
        end
    end

    // One clock: drive inputs, sample at negedge, step model, advance PC on acceptance.
    task automatic cyc(input bit f, input bit r, input bit rv, input logic [31:0] rd, input bit ir);
        bit acc_pred;
        bus.flush         = f;
        bus.ic_req_ready  = r;
        bus.ic_resp_valid = rv;
        bus.ic_resp_data  = rd;
        bus.ifq_ready     = ir;
        @(negedge clk);
        s_valid  = bus.ic_req_valid;
        s_we     = bus.pc_we;
        s_addr   = bus.ic_req_addr;
        s_qv     = bus.ifq_valid;
        s_qpc    = bus.ifq_pc;
        s_qinst  = bus.ifq_inst;
        acc_pred = m_valid() && r;
        @(posedge clk);
        m_step();
        #1;
        if (acc_pred) bus.pc = bus.pc + 32'd4;
    endtask

    initial begin
        int n;
        rst               = 1'b1;
        bus.pc            = 32'h0;
        bus.flush         = 1'b0;
        bus.ic_req_ready  = 1'b0;
        bus.ic_resp_valid = 1'b0;
        bus.ic_resp_data  = 32'h0;
        bus.ifq_ready     = 1'b0;
        repeat (3) @(posedge clk);
        m_reset();
        #1;
        rst    = 1'b0;
        bus.pc = 32'h1C00_0000;

        // 1: first cycle after reset is quiet, then issue; response lands in the queue
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t1_reset_valid", 32'(s_valid), 32'd0);
        chk("t1_reset_we", 32'(s_we), 32'd0);
        chk("t1_reset_qv", 32'(s_qv), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t1_we", 32'(s_we), 32'd1);
        chk("t1_addr", s_addr, 32'h1C00_0000);
        cyc(1'b0, 1'b0, 1'b1, 32'h0280_0000, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t1_qv", 32'(s_qv), 32'd1);
        chk("t1_qpc", s_qpc, 32'h1C00_0000);
        chk("t1_qinst", s_qinst, 32'h0280_0000);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // 2: without responses only MAX_OUT requests are accepted
        n = 0;
        repeat (4) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            n += int'(s_we);
        end
        chk("t2_accepts", 32'(n), 32'd2);
        chk("t2_stalled", 32'(s_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_00A0, 1'b0);
        chk("t2_still_full", 32'(s_valid), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("t2_resume", 32'(s_valid), 32'd1);

        // 3: decode stalled, issue stops once queued+outstanding reaches the depth
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b1, (m_tagq.size() != 0), 32'hD000_0000 + 32'(k), 1'b0);
        end
        chk("t3_stop", 32'(s_valid), 32'd0);
        chk("t3_model_q", 32'(m_ifq.size()), 32'd4);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t3_pc0", s_qpc, 32'h1C00_0004);
        chk("t3_inst0", s_qinst, 32'h0000_00A0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t3_pc1", s_qpc, 32'h1C00_0008);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t3_pc2", s_qpc, 32'h1C00_000C);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t3_pc3", s_qpc, 32'h1C00_0010);

        // 4: flush with two outstanding and a response the same cycle -> one dropped response
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 32'h0000_BAD0, 1'b1);
        chk("t4_flush_valid", 32'(s_valid), 32'd0);
        chk("t4_flush_we", 32'(s_we), 32'd0);
        bus.pc = 32'h1C00_0100;
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t4_drain_valid", 32'(s_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_BAD1, 1'b1);
        chk("t4_drain_valid2", 32'(s_valid), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t4_dropped", 32'(s_qv), 32'd0);
        chk("t4_reissue", 32'(s_we), 32'd1);
        chk("t4_addr", s_addr, 32'h1C00_0100);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0013, 1'b1);

        // 5: flush with nothing outstanding and a full queue
        for (int k = 0; k < 12; k++) begin
            if (m_ifq.size() == DEPTH && m_tagq.size() == 0) break;
            cyc(1'b0, 1'b1, (m_tagq.size() != 0), 32'hE000_0000 + 32'(k), 1'b0);
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("t5_flush_valid", 32'(s_valid), 32'd0);
        chk("t5_full_head", s_qpc, 32'h1C00_0100);
        bus.pc = 32'h1C00_0200;
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("t5_empty", 32'(s_qv), 32'd0);
        chk("t5_issue", 32'(s_we), 32'd1);
        chk("t5_addr", s_addr, 32'h1C00_0200);
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_00F0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("t5_qpc", s_qpc, 32'h1C00_0200);
        chk("t5_qinst", s_qinst, 32'h0000_00F0);

        // 6: random traffic against the model
        for (int k = 0; k < 10000; k++) begin
            bit f;
            f = ($urandom_range(0, 31) == 0);
            cyc(f, 1'($urandom_range(0, 1)),
                (m_tagq.size() != 0) && ($urandom_range(0, 9) < 6),
                $urandom, 1'($urandom_range(0, 1)));
            if (f) bus.pc = $urandom & 32'hFFFF_FFFC;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
